// File: rtl/spatz_vrf_wb_buffer_if.sv
// Interface bundling the producer request, VRF write port and hazard-check signals
// of the Spatz VRF write-back buffer.
interface spatz_vrf_wb_buffer_if #(
  parameter int unsigned AddrWidth = 8,
  parameter int unsigned DataWidth = 32
);
  localparam int unsigned BeWidth = DataWidth / 8;

  logic                 req_valid_i;
  logic                 req_ready_o;
  logic [AddrWidth-1:0] req_addr_i;
  logic [DataWidth-1:0] req_data_i;
  logic [BeWidth-1:0]   req_be_i;

  logic                 vrf_we_o;
  logic [AddrWidth-1:0] vrf_waddr_o;
  logic [DataWidth-1:0] vrf_wdata_o;
  logic [BeWidth-1:0]   vrf_wbe_o;
  logic                 vrf_wvalid_i;

  logic [AddrWidth-1:0] hazard_addr_i;
  logic                 hazard_o;
  logic                 empty_o;

  modport slave (
    input  req_valid_i, req_addr_i, req_data_i, req_be_i, vrf_wvalid_i, hazard_addr_i,
    output req_ready_o, vrf_we_o, vrf_waddr_o, vrf_wdata_o, vrf_wbe_o, hazard_o, empty_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_data_i, req_be_i, vrf_wvalid_i, hazard_addr_i,
    input  req_ready_o, vrf_we_o, vrf_waddr_o, vrf_wdata_o, vrf_wbe_o, hazard_o, empty_o
  );
endinterface

// File: rtl/spatz_vrf_wb_buffer.sv
// Circular FIFO that buffers VRF writes until the VRF write port grants them.
// Optional feature: define SPATZ_VRF_WB_STALL_CNT_EN to add the stall_cnt_o counter.
module spatz_vrf_wb_buffer #(
  parameter int          Depth     = 2,
  parameter int unsigned AddrWidth = 8,
  parameter int unsigned DataWidth = 32
) (
  input  logic        clk_i,
  input  logic        rst_ni,
`ifdef SPATZ_VRF_WB_STALL_CNT_EN
  output logic [15:0] stall_cnt_o,
`endif
  spatz_vrf_wb_buffer_if.slave bus
);
  localparam int unsigned BeWidth = DataWidth / 8;
  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);
  localparam int SumW = PtrW + 1;
  localparam logic [PtrW-1:0] LastPtr  = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);
  localparam logic [SumW-1:0] DepthSum = SumW'(Depth);

  typedef logic [AddrWidth-1:0] vreg_addr_t;
  typedef logic [DataWidth-1:0] vreg_data_t;
  typedef logic [BeWidth-1:0]   vreg_be_t;

  if (Depth < 1) begin : g_depth_check
    $error("spatz_vrf_wb_buffer: Depth must be at least 1");
  end

  vreg_addr_t addr_q [Depth];
  vreg_data_t data_q [Depth];
  vreg_be_t   be_q   [Depth];

  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            ready;
  logic            not_empty;
  logic            push;
  logic            pop;
  logic            hazard;
  logic [SumW-1:0] slot_sum;
  logic [PtrW-1:0] slot;

  // Explicit wrap keeps non-power-of-two depths from walking past the last slot.
  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
    return (ptr == LastPtr) ? '0 : ptr + 1'b1;
  endfunction

  assign ready     = (count_q < DepthCnt);
  assign not_empty = (count_q != '0);
  assign push      = bus.req_valid_i && ready;
  assign pop       = not_empty && bus.vrf_wvalid_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload storage is deliberately left without reset; occupancy alone marks validity.
  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_q[wr_ptr_q] <= bus.req_addr_i;
      data_q[wr_ptr_q] <= bus.req_data_i;
      be_q[wr_ptr_q]   <= bus.req_be_i;
    end
  end

  // Walk the occupied slots from the head; the head counts even while it is popping.
  always_comb begin
    hazard   = 1'b0;
    slot_sum = '0;
    slot     = '0;
    for (int k = 0; k < Depth; k++) begin
      slot_sum = {1'b0, rd_ptr_q} + SumW'(k);
      if (slot_sum >= DepthSum) slot_sum = slot_sum - DepthSum;
      slot = slot_sum[PtrW-1:0];
      if ((CntW'(k) < count_q) && (addr_q[slot] == bus.hazard_addr_i)) hazard = 1'b1;
    end
  end

  assign bus.req_ready_o = ready;
  assign bus.vrf_we_o    = not_empty;
  assign bus.vrf_waddr_o = not_empty ? addr_q[rd_ptr_q] : '0;
  assign bus.vrf_wdata_o = not_empty ? data_q[rd_ptr_q] : '0;
  assign bus.vrf_wbe_o   = not_empty ? be_q[rd_ptr_q]   : '0;
  assign bus.hazard_o    = hazard;
  assign bus.empty_o     = !not_empty;

`ifdef SPATZ_VRF_WB_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
    end else if (not_empty && !bus.vrf_wvalid_i && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif
endmodule

// File: tb/tb_spatz_vrf_wb_buffer.sv
// Directed self-checking bench for spatz_vrf_wb_buffer (Depth=2 and Depth=3 instances).
module tb_spatz_vrf_wb_buffer;
  localparam int AW = 8;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  spatz_vrf_wb_buffer_if #(.AddrWidth(AW), .DataWidth(DW)) bus2 ();
  spatz_vrf_wb_buffer_if #(.AddrWidth(AW), .DataWidth(DW)) bus3 ();

`ifdef SPATZ_VRF_WB_STALL_CNT_EN
  logic [15:0] stall2;
  logic [15:0] stall3;
`endif

  spatz_vrf_wb_buffer #(.Depth(2), .AddrWidth(AW), .DataWidth(DW)) dut2 (
    .clk_i       (clk),
    .rst_ni      (rst_n),
`ifdef SPATZ_VRF_WB_STALL_CNT_EN
    .stall_cnt_o (stall2),
`endif
    .bus         (bus2.slave)
  );

  spatz_vrf_wb_buffer #(.Depth(3), .AddrWidth(AW), .DataWidth(DW)) dut3 (
    .clk_i       (clk),
    .rst_ni      (rst_n),
`ifdef SPATZ_VRF_WB_STALL_CNT_EN
    .stall_cnt_o (stall3),
`endif
    .bus         (bus3.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus2.req_valid_i = 0; bus2.req_addr_i = '0; bus2.req_data_i = '0; bus2.req_be_i = '0;
    bus2.vrf_wvalid_i = 0; bus2.hazard_addr_i = '0;
    bus3.req_valid_i = 0; bus3.req_addr_i = '0; bus3.req_data_i = '0; bus3.req_be_i = '0;
    bus3.vrf_wvalid_i = 0; bus3.hazard_addr_i = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0; step(); step(); rst_n = 1;
    tests++; if (bus2.vrf_we_o !== 1'b0) begin fails++; $display("[TB] FAIL reset_we got %0b want 0", bus2.vrf_we_o); end
    tests++; if (bus2.empty_o !== 1'b1) begin fails++; $display("[TB] FAIL reset_empty got %0b want 1", bus2.empty_o); end
    tests++; if (bus2.req_ready_o !== 1'b1) begin fails++; $display("[TB] FAIL reset_ready got %0b want 1", bus2.req_ready_o); end
    tests++; if (bus2.hazard_o !== 1'b0) begin fails++; $display("[TB] FAIL reset_hazard got %0b want 0", bus2.hazard_o); end
    tests++; if (bus2.vrf_waddr_o !== 8'h00 || bus2.vrf_wdata_o !== 32'h0 || bus2.vrf_wbe_o !== 4'h0) begin
      fails++; $display("[TB] FAIL reset_fields got %h/%h/%h want 0/0/0", bus2.vrf_waddr_o, bus2.vrf_wdata_o, bus2.vrf_wbe_o); end
    tests++; if (bus3.vrf_we_o !== 1'b0 || bus3.empty_o !== 1'b1) begin
      fails++; $display("[TB] FAIL reset_d3 got we=%0b empty=%0b want we=0 empty=1", bus3.vrf_we_o, bus3.empty_o); end
  endtask

  task automatic test_single_write();
    bus2.vrf_wvalid_i = 1;
    bus2.req_valid_i = 1; bus2.req_addr_i = 8'h05; bus2.req_data_i = 32'hA5; bus2.req_be_i = 4'hF;
    #1;
    tests++; if (bus2.vrf_we_o !== 1'b0) begin fails++; $display("[TB] FAIL single_no_bypass got we=%0b want 0", bus2.vrf_we_o); end
    step(); bus2.req_valid_i = 0;
    tests++; if (bus2.vrf_we_o !== 1'b1 || bus2.vrf_waddr_o !== 8'h05) begin
      fails++; $display("[TB] FAIL single_c1 got we=%0b addr=%h want we=1 addr=05", bus2.vrf_we_o, bus2.vrf_waddr_o); end
    tests++; if (bus2.vrf_wdata_o !== 32'hA5 || bus2.vrf_wbe_o !== 4'hF) begin
      fails++; $display("[TB] FAIL single_data got %h/%h want 000000a5/f", bus2.vrf_wdata_o, bus2.vrf_wbe_o); end
    step();
    tests++; if (bus2.vrf_we_o !== 1'b0 || bus2.empty_o !== 1'b1) begin
      fails++; $display("[TB] FAIL single_c2 got we=%0b empty=%0b want we=0 empty=1", bus2.vrf_we_o, bus2.empty_o); end
    bus2.vrf_wvalid_i = 0;
  endtask

  task automatic test_back_pressure();
    bus2.vrf_wvalid_i = 0; bus2.req_be_i = 4'h3;
    bus2.req_valid_i = 1; bus2.req_addr_i = 8'h01; bus2.req_data_i = 32'h101;
    step();
    tests++; if (bus2.req_ready_o !== 1'b1 || bus2.empty_o !== 1'b0) begin
      fails++; $display("[TB] FAIL bp_one got ready=%0b empty=%0b want 1/0", bus2.req_ready_o, bus2.empty_o); end
    bus2.req_addr_i = 8'h02; bus2.req_data_i = 32'h102;
    step();
    tests++; if (bus2.req_ready_o !== 1'b0 || bus2.vrf_waddr_o !== 8'h01) begin
      fails++; $display("[TB] FAIL bp_full got ready=%0b addr=%h want 0/01", bus2.req_ready_o, bus2.vrf_waddr_o); end
    bus2.req_addr_i = 8'h03; bus2.req_data_i = 32'h103;
    step();
    tests++; if (bus2.req_ready_o !== 1'b0 || bus2.vrf_waddr_o !== 8'h01 || bus2.vrf_wdata_o !== 32'h101) begin
      fails++; $display("[TB] FAIL bp_hold got ready=%0b addr=%h data=%h want 0/01/101", bus2.req_ready_o, bus2.vrf_waddr_o, bus2.vrf_wdata_o); end
    bus2.vrf_wvalid_i = 1; #1;
    tests++; if (bus2.req_ready_o !== 1'b0) begin fails++; $display("[TB] FAIL bp_no_comb_ready got %0b want 0", bus2.req_ready_o); end
    step();
    tests++; if (bus2.req_ready_o !== 1'b1 || bus2.vrf_waddr_o !== 8'h02) begin
      fails++; $display("[TB] FAIL bp_after_grant got ready=%0b addr=%h want 1/02", bus2.req_ready_o, bus2.vrf_waddr_o); end
    bus2.vrf_wvalid_i = 0;
    step();
    bus2.req_valid_i = 0;
    tests++; if (bus2.req_ready_o !== 1'b0 || bus2.vrf_waddr_o !== 8'h02) begin
      fails++; $display("[TB] FAIL bp_third_in got ready=%0b addr=%h want 0/02", bus2.req_ready_o, bus2.vrf_waddr_o); end
    bus2.vrf_wvalid_i = 1;
    step();
    tests++; if (bus2.vrf_waddr_o !== 8'h03 || bus2.vrf_wdata_o !== 32'h103) begin
      fails++; $display("[TB] FAIL bp_order3 got addr=%h data=%h want 03/103", bus2.vrf_waddr_o, bus2.vrf_wdata_o); end
    step();
    tests++; if (bus2.empty_o !== 1'b1 || bus2.vrf_we_o !== 1'b0) begin
      fails++; $display("[TB] FAIL bp_drained got empty=%0b we=%0b want 1/0", bus2.empty_o, bus2.vrf_we_o); end
    bus2.vrf_wvalid_i = 0;
  endtask

  task automatic test_hazard();
    bus2.vrf_wvalid_i = 0;
    bus2.req_valid_i = 1; bus2.req_addr_i = 8'h04; step();
    bus2.req_addr_i = 8'h09; step();
    bus2.req_valid_i = 0;
    bus2.hazard_addr_i = 8'h09; #1;
    tests++; if (bus2.hazard_o !== 1'b1) begin fails++; $display("[TB] FAIL hazard_second got %0b want 1", bus2.hazard_o); end
    bus2.hazard_addr_i = 8'h07; #1;
    tests++; if (bus2.hazard_o !== 1'b0) begin fails++; $display("[TB] FAIL hazard_miss got %0b want 0", bus2.hazard_o); end
    bus2.hazard_addr_i = 8'h89; #1;
    tests++; if (bus2.hazard_o !== 1'b0) begin fails++; $display("[TB] FAIL hazard_full_addr got %0b want 0", bus2.hazard_o); end
    bus2.hazard_addr_i = 8'h09; bus2.vrf_wvalid_i = 1;
    step();
    tests++; if (bus2.vrf_waddr_o !== 8'h09 || bus2.hazard_o !== 1'b1) begin
      fails++; $display("[TB] FAIL hazard_popping got addr=%h hz=%0b want 09/1", bus2.vrf_waddr_o, bus2.hazard_o); end
    step();
    tests++; if (bus2.hazard_o !== 1'b0 || bus2.empty_o !== 1'b1) begin
      fails++; $display("[TB] FAIL hazard_cleared got hz=%0b empty=%0b want 0/1", bus2.hazard_o, bus2.empty_o); end
    bus2.hazard_addr_i = 8'h04; #1;
    tests++; if (bus2.hazard_o !== 1'b0) begin fails++; $display("[TB] FAIL hazard_stale got %0b want 0", bus2.hazard_o); end
    bus2.vrf_wvalid_i = 0; bus2.hazard_addr_i = '0;
  endtask

  task automatic test_reset_mid();
    bus2.vrf_wvalid_i = 0;
    bus2.req_valid_i = 1; bus2.req_addr_i = 8'h21; step();
    bus2.req_addr_i = 8'h22; step();
    bus2.req_valid_i = 0;
    tests++; if (bus2.vrf_we_o !== 1'b1) begin fails++; $display("[TB] FAIL rstmid_pending got we=%0b want 1", bus2.vrf_we_o); end
    rst_n = 0; step(); rst_n = 1;
    tests++; if (bus2.vrf_we_o !== 1'b0 || bus2.empty_o !== 1'b1 || bus2.req_ready_o !== 1'b1) begin
      fails++; $display("[TB] FAIL rstmid_state got we=%0b empty=%0b ready=%0b want 0/1/1", bus2.vrf_we_o, bus2.empty_o, bus2.req_ready_o); end
    bus2.vrf_wvalid_i = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++; if (bus2.vrf_we_o !== 1'b0) begin fails++; $display("[TB] FAIL rstmid_no_write cycle %0d got we=%0b want 0", i, bus2.vrf_we_o); end
    end
    bus2.vrf_wvalid_i = 0;
  endtask

  task automatic test_wrap_depth3();
    logic [7:0] q[$];
    logic [7:0] nxt;
    bit         can_push;
    bus3.vrf_wvalid_i = 0; bus3.req_be_i = 4'hF; bus3.req_valid_i = 1;
    for (int i = 0; i < 3; i++) begin
      bus3.req_addr_i = 8'h30 + 8'(i); bus3.req_data_i = 32'h1030 + 32'(i);
      q.push_back(8'h30 + 8'(i));
      step();
    end
    tests++; if (bus3.req_ready_o !== 1'b0 || bus3.vrf_waddr_o !== 8'h30) begin
      fails++; $display("[TB] FAIL wrap_full got ready=%0b addr=%h want 0/30", bus3.req_ready_o, bus3.vrf_waddr_o); end
    nxt = 8'h33;
    bus3.vrf_wvalid_i = 1;
    for (int c = 0; c < 10; c++) begin
      bus3.req_addr_i = nxt; bus3.req_data_i = 32'h1000 + 32'(nxt);
      #1;
      tests++; if (bus3.vrf_waddr_o !== q[0] || bus3.vrf_wdata_o !== 32'h1000 + 32'(q[0])) begin
        fails++; $display("[TB] FAIL wrap_head cycle %0d got %h/%h want %h", c, bus3.vrf_waddr_o, bus3.vrf_wdata_o, q[0]); end
      can_push = (q.size() < 3);
      tests++; if (bus3.req_ready_o !== can_push) begin
        fails++; $display("[TB] FAIL wrap_ready cycle %0d got %0b want %0b", c, bus3.req_ready_o, can_push); end
      void'(q.pop_front());
      if (can_push) begin q.push_back(nxt); nxt = nxt + 8'h01; end
      step();
    end
    bus3.req_valid_i = 0;
    for (int i = 0; i < 6 && q.size() > 0; i++) begin
      tests++; if (bus3.vrf_waddr_o !== q[0]) begin
        fails++; $display("[TB] FAIL wrap_drain got %h want %h", bus3.vrf_waddr_o, q[0]); end
      void'(q.pop_front());
      step();
    end
    tests++; if (bus3.empty_o !== 1'b1) begin fails++; $display("[TB] FAIL wrap_empty got %0b want 1", bus3.empty_o); end
    bus3.vrf_wvalid_i = 0;
  endtask

`ifdef SPATZ_VRF_WB_STALL_CNT_EN
  task automatic test_stall_cnt();
    idle_inputs();
    rst_n = 0; step(); rst_n = 1;
    tests++; if (stall2 !== 16'd0) begin fails++; $display("[TB] FAIL stall_reset got %0d want 0", stall2); end
    bus2.req_valid_i = 1; bus2.req_addr_i = 8'h40; step();
    bus2.req_valid_i = 0;
    for (int i = 0; i < 5; i++) step();
    tests++; if (stall2 !== 16'd5 || bus2.vrf_we_o !== 1'b1) begin
      fails++; $display("[TB] FAIL stall_five got cnt=%0d we=%0b want 5/1", stall2, bus2.vrf_we_o); end
    bus2.vrf_wvalid_i = 1; step();
    tests++; if (stall2 !== 16'd5 || bus2.empty_o !== 1'b1) begin
      fails++; $display("[TB] FAIL stall_grant got cnt=%0d empty=%0b want 5/1", stall2, bus2.empty_o); end
    bus2.vrf_wvalid_i = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_single_write();
    test_back_pressure();
    test_hazard();
    test_reset_mid();
    test_wrap_depth3();
`ifdef SPATZ_VRF_WB_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout got running want finished");
    $fatal(1, "[TB] timeout");
  end
endmodule
